// File: rtl/uart_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deframer
// Purpose  : UART receive deframer. Synchronises the serial rx pin, finds
//            start bits, samples 5..8 data bits, optional parity and 1 or 2
//            stop bits at mid-bit using an oversampling tick, and hands each
//            character plus its error flags to the RX FIFO over valid/ready.
// Ports    : clk, reset_n (async, active low)
//            rx                  serial input (async, idle high)
//            rx_en               receiver enable
//            divisor             clk cycles per oversample tick (0 = frozen)
//            data_bits/parity_en/parity_odd/stop2   line configuration
//            rx_data/rx_valid/rx_ready              output handshake
//            parity_err/frame_err                   flags qualified by rx_valid
//            overrun             1-clk pulse when a completed frame is dropped
//            busy                receiver not idle
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_deframer #(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx,
    input  logic             rx_en,
    input  logic [DIV_W-1:0] divisor,
    input  logic [1:0]       data_bits,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             stop2,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int                  c_SCNT_W    = $clog2(OVERSAMPLE);
    localparam logic [c_SCNT_W-1:0] c_SCNT_MID  = c_SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_SCNT_W-1:0] c_SCNT_LAST = c_SCNT_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Synchroniser and edge-detect stage; all reset to the idle (high) level
    logic r_rx_meta;
    logic r_rx_s;
    logic r_rx_s_d;

    // Frame configuration captured at start detection
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_data_bits;
    logic             r_par_en;
    logic             r_par_odd;
    logic             r_stop2;

    logic [DIV_W-1:0]    r_div_cnt;
    logic [c_SCNT_W-1:0] r_scnt;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic                r_par;
    logic                r_perr_acc;
    logic                r_ferr_acc;
    logic                r_stop_cnt;

    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_parity_err;
    logic       r_frame_err;
    logic       r_overrun;

    logic w_start;
    logic w_tick;
    logic w_mid_start;
    logic w_sample;
    logic w_last_data;
    logic w_last_stop;
    logic w_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_s_d  <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_s_d  <= r_rx_s;
        end
    end

    // Falling edge only: a line stuck low cannot retrigger a frame
    assign w_start = rx_en && r_rx_s_d && !r_rx_s;

    // Oversample tick; the counter is held at zero while idle so every frame
    // starts with a full tick period after the start edge
    assign w_tick = (r_state != S_IDLE) && (r_div != '0) &&
                    (r_div_cnt == r_div - DIV_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
        end else if ((r_state == S_IDLE) || (r_div == '0) || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Start bit is checked half a bit in; after re-zeroing scnt there, every
    // wrap of scnt lands in the middle of the following bit
    assign w_mid_start = w_tick && (r_state == S_START) && (r_scnt == c_SCNT_MID);
    assign w_sample    = w_tick && (r_scnt == c_SCNT_LAST);
    assign w_last_data = (r_bit_cnt == ({1'b0, r_data_bits} + 3'd4));
    assign w_last_stop = r_stop2 ? r_stop_cnt : 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scnt <= '0;
        end else if ((r_state == S_IDLE) || w_mid_start) begin
            r_scnt <= '0;
        end else if (w_tick) begin
            r_scnt <= r_scnt + c_SCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        if (!rx_en) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) w_state_nxt = S_START;
                end
                S_START: begin
                    if (w_mid_start) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (w_sample && w_last_data) w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                end
                S_PARITY: begin
                    if (w_sample) w_state_nxt = S_STOP;
                end
                S_STOP: begin
                    if (w_sample && w_last_stop) begin
                        w_state_nxt = S_IDLE;
                        w_done      = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Frame datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div       <= '0;
            r_data_bits <= '0;
            r_par_en    <= 1'b0;
            r_par_odd   <= 1'b0;
            r_stop2     <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_perr_acc  <= 1'b0;
            r_ferr_acc  <= 1'b0;
            r_stop_cnt  <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && w_start) begin
                r_div       <= divisor;
                r_data_bits <= data_bits;
                r_par_en    <= parity_en;
                r_par_odd   <= parity_odd;
                r_stop2     <= stop2;
            end
            if (w_mid_start) begin
                r_bit_cnt  <= '0;
                r_shift    <= '0;
                r_par      <= 1'b0;
                r_perr_acc <= 1'b0;
                r_ferr_acc <= 1'b0;
                r_stop_cnt <= 1'b0;
            end
            if ((r_state == S_DATA) && w_sample) begin
                // Indexed write keeps short characters LSB-aligned with zero MSBs
                r_shift[r_bit_cnt] <= r_rx_s;
                r_par              <= r_par ^ r_rx_s;
                r_bit_cnt          <= r_bit_cnt + 3'd1;
            end
            if ((r_state == S_PARITY) && w_sample) begin
                r_perr_acc <= ((r_par ^ r_rx_s) != r_par_odd);
            end
            if ((r_state == S_STOP) && w_sample) begin
                if (!r_rx_s) r_ferr_acc <= 1'b1;
                r_stop_cnt <= 1'b1;
            end
        end
    end

    // Holding register and handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_done) begin
                if (r_rx_valid && !rx_ready) begin
                    r_overrun <= 1'b1;
                end else begin
                    // The final stop sample is folded in directly here
                    r_rx_data    <= r_shift;
                    r_parity_err <= r_perr_acc;
                    r_frame_err  <= r_ferr_acc | ~r_rx_s;
                    r_rx_valid   <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_deframer
// Purpose  : Self-checking bench for uart_rx_deframer. Expected characters are
//            queued as frames are driven and compared against characters the
//            DUT hands over on rx_valid & rx_ready.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_deframer;

    localparam int c_OS  = 16;
    localparam int c_DIV = 2;
    localparam int c_BIT = c_OS * c_DIV;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx = 1'b1;
    logic        rx_en = 1'b0;
    logic [15:0] divisor = 16'(c_DIV);
    logic [1:0]  data_bits = 2'd3;
    logic        parity_en = 1'b0;
    logic        parity_odd = 1'b0;
    logic        stop2 = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b1;
    logic        parity_err;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    uart_rx_deframer #(.OVERSAMPLE(c_OS), .DIV_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .rx_en      (rx_en),
        .divisor    (divisor),
        .data_bits  (data_bits),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
    } frame_t;

    frame_t exp_q[$];
    frame_t obs_q[$];

    int checks   = 0;
    int failures = 0;

    int cyc = 0;
    int t_start_fall = 0;
    int t_busy_rise  = 0;
    int t_valid_rise = 0;
    int busy_rises   = 0;
    int valid_cycles = 0;
    int ovr_cycles   = 0;
    logic busy_q  = 1'b0;
    logic valid_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation side of the scoreboard, sampled on the inactive edge
    always @(negedge clk) begin
        if (rx_valid && rx_ready) obs_q.push_back({rx_data, parity_err, frame_err});
        if (rx_valid) valid_cycles++;
        if (overrun) ovr_cycles++;
        if (busy && !busy_q) begin
            busy_rises++;
            t_busy_rise = cyc;
        end
        if (rx_valid && !valid_q) t_valid_rise = cyc;
        busy_q  = busy;
        valid_q = rx_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; holds one bit period and returns at posedge+1
    task automatic drive_bit(input logic b);
        rx = b;
        repeat (c_BIT) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                              input logic pbit, input int nstop, input logic s2,
                              input logic idle_after);
        t_start_fall = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < nb; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        drive_bit(1'b1);
        if (nstop == 2) drive_bit(s2);
        if (idle_after) begin
            drive_bit(1'b1);
            drive_bit(1'b1);
        end
    endtask

    task automatic test_reset;
        reset_n  = 1'b0;
        rx       = 1'b1;
        rx_en    = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rx_data, rx_valid, parity_err, frame_err, overrun, busy} !== 13'd0) begin
            failures++;
            $display("FAIL reset_held: outputs=%h required=0",
                     {rx_data, rx_valid, parity_err, frame_err, overrun, busy});
        end
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({rx_data, rx_valid, parity_err, frame_err, overrun, busy} !== 13'd0) begin
            failures++;
            $display("FAIL reset_released: outputs=%h required=0",
                     {rx_data, rx_valid, parity_err, frame_err, overrun, busy});
        end
    endtask

    task automatic test_8n1;
        int vc0;
        int ov0;
        frame_t e;
        frame_t o;
        data_bits = 2'd3; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
        rx_ready  = 1'b1;
        vc0 = valid_cycles;
        ov0 = ovr_cycles;
        exp_q.push_back({8'hA5, 1'b0, 1'b0});
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b0, 1'b1);
        checks++;
        if (t_busy_rise - t_start_fall !== 3) begin
            failures++;
            $display("FAIL busy_latency: got %0d clk required 3", t_busy_rise - t_start_fall);
        end
        // Last stop sample falls on tick 8 + 16*9 of the frame (div 2) plus 3 sync/state clk
        checks++;
        if (t_valid_rise - t_start_fall !== 3 + c_DIV * (c_OS / 2 + c_OS * 9)) begin
            failures++;
            $display("FAIL valid_latency: got %0d clk required %0d",
                     t_valid_rise - t_start_fall, 3 + c_DIV * (c_OS / 2 + c_OS * 9));
        end
        checks++;
        if (valid_cycles - vc0 !== 1) begin
            failures++;
            $display("FAIL valid_width: got %0d clk required 1", valid_cycles - vc0);
        end
        checks++;
        if (ovr_cycles - ov0 !== 0) begin
            failures++;
            $display("FAIL 8n1_overrun: got %0d required 0", ovr_cycles - ov0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL 8n1_frame: none received, expected data=%h pe=%b fe=%b", e.data, e.pe, e.fe);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL 8n1_frame: got data=%h pe=%b fe=%b expected data=%h pe=%b fe=%b",
                             o.data, o.pe, o.fe, e.data, e.pe, e.fe);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL 8n1_extra: got %0d extra frames required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_parity;
        frame_t e;
        frame_t o;
        data_bits = 2'd2; parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b0;
        // 0x41 has two ones: even parity wants 0, so a forced 1 is an error
        exp_q.push_back({8'h41, 1'b1, 1'b0});
        send_frame(8'h41, 7, 1'b1, 1'b1, 1, 1'b0, 1'b1);
        parity_odd = 1'b1;
        exp_q.push_back({8'h41, 1'b0, 1'b0});
        send_frame(8'h41, 7, 1'b1, 1'b1, 1, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL parity_frame: none received, expected data=%h pe=%b fe=%b", e.data, e.pe, e.fe);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL parity_frame: got data=%h pe=%b fe=%b expected data=%h pe=%b fe=%b",
                             o.data, o.pe, o.fe, e.data, e.pe, e.fe);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL parity_extra: got %0d extra frames required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_frame_err;
        int br0;
        frame_t e;
        frame_t o;
        data_bits = 2'd3; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b1;
        exp_q.push_back({8'h96, 1'b0, 1'b1});
        send_frame(8'h96, 8, 1'b0, 1'b0, 2, 1'b0, 1'b0);
        br0 = busy_rises;
        // Line stays low for ten frame times after the bad stop bit
        repeat (10 * 11) drive_bit(1'b0);
        checks++;
        if (busy_rises !== br0) begin
            failures++;
            $display("FAIL stuck_low_busy_rises: got %0d required 0", busy_rises - br0);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL stuck_low_busy: got %b required 0", busy);
        end
        drive_bit(1'b1);
        drive_bit(1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL frame_err_frame: none received, expected data=%h pe=%b fe=%b", e.data, e.pe, e.fe);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL frame_err_frame: got data=%h pe=%b fe=%b expected data=%h pe=%b fe=%b",
                             o.data, o.pe, o.fe, e.data, e.pe, e.fe);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL frame_err_extra: got %0d extra frames required 0", obs_q.size());
            obs_q.delete();
        end
        stop2 = 1'b0;
    endtask

    task automatic test_glitch;
        int br0;
        int vc0;
        br0 = busy_rises;
        vc0 = valid_cycles;
        rx = 1'b0;
        repeat (4 * c_DIV) @(posedge clk);
        #1;
        rx = 1'b1;
        drive_bit(1'b1);
        drive_bit(1'b1);
        checks++;
        if (busy_rises - br0 !== 1) begin
            failures++;
            $display("FAIL glitch_busy_pulse: got %0d rises required 1", busy_rises - br0);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_idle: busy=%b required 0", busy);
        end
        checks++;
        if (valid_cycles - vc0 !== 0 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL glitch_no_output: got %0d valid cycles required 0", valid_cycles - vc0);
            obs_q.delete();
        end
    endtask

    task automatic test_overrun;
        int ov0;
        frame_t e;
        frame_t o;
        data_bits = 2'd3; parity_en = 1'b0; stop2 = 1'b0;
        rx_ready = 1'b0;
        ov0 = ovr_cycles;
        exp_q.push_back({8'h11, 1'b0, 1'b0});
        send_frame(8'h11, 8, 1'b0, 1'b0, 1, 1'b0, 1'b1);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1, 1'b0, 1'b1);
        checks++;
        if (ovr_cycles - ov0 !== 1) begin
            failures++;
            $display("FAIL overrun_pulse: got %0d clk required 1", ovr_cycles - ov0);
        end
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
            failures++;
            $display("FAIL overrun_hold: got valid=%b data=%h required valid=1 data=11", rx_valid, rx_data);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL overrun_drain: rx_valid=%b required 0", rx_valid);
        end
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL overrun_frame: none received, expected data=%h", e.data);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL overrun_frame: got data=%h pe=%b fe=%b expected data=%h pe=%b fe=%b",
                             o.data, o.pe, o.fe, e.data, e.pe, e.fe);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL overrun_extra: got %0d extra frames required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid;
        frame_t e;
        frame_t o;
        logic [7:0] part;
        data_bits = 2'd3; parity_en = 1'b0; stop2 = 1'b0;
        // Park a character in the holding register so reset has something to clear
        rx_ready = 1'b0;
        send_frame(8'h77, 8, 1'b0, 1'b0, 1, 1'b0, 1'b1);
        part = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(part[i]);
        checks++;
        if (busy !== 1'b1 || rx_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_frame_state: busy=%b valid=%b required 1 1", busy, rx_valid);
        end
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rx_data, rx_valid, parity_err, frame_err, overrun, busy} !== 13'd0) begin
            failures++;
            $display("FAIL async_reset: outputs=%h required 0",
                     {rx_data, rx_valid, parity_err, frame_err, overrun, busy});
        end
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n  = 1'b1;
        rx_ready = 1'b1;
        drive_bit(1'b1);
        drive_bit(1'b1);
        exp_q.push_back({8'h3C, 1'b0, 1'b0});
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL post_reset_frame: none received, expected data=%h", e.data);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    failures++;
                    $display("FAIL post_reset_frame: got data=%h pe=%b fe=%b expected data=%h pe=%b fe=%b",
                             o.data, o.pe, o.fe, e.data, e.pe, e.fe);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL post_reset_extra: got %0d extra frames required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    initial begin
        test_reset;
        test_8n1;
        test_parity;
        test_frame_err;
        test_glitch;
        test_overrun;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
